// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Round-robin arbiter/sequencer granting two load/store requesters
//            single-cycle access to the byte-addressed data memory.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  // requester A (core load/store port)
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic              a_sext,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [31:0]       a_rdata,
  output logic              a_err,
  // requester B (debug/DMA port)
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_size,
  input  logic              b_sext,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [31:0]       b_rdata,
  output logic              b_err,
  // memory side
  output logic              write_mem_4B,
  output logic              write_mem_2B,
  output logic              write_mem_1B,
  output logic              read_mem_4B,
  output logic              read_mem_2B,
  output logic              read_mem_1B,
  output logic              extension_mem,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       write_data,
  input  logic [31:0]       out_mem
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;
  localparam logic [1:0] c_size_word = 2'b10;
  localparam logic [1:0] c_size_bad  = 2'b11;
  localparam logic       c_id_a      = 1'b0;
  localparam logic       c_id_b      = 1'b1;
  localparam logic [ADDR_W:0] c_mem_limit = (ADDR_W+1)'(MEM_BYTES);

  state_t r_state;
  state_t w_state_nxt;

  logic              r_last;
  logic              r_id;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              r_a_rvalid;
  logic [31:0]       r_a_rdata;
  logic              r_a_err;
  logic              r_b_rvalid;
  logic [31:0]       r_b_rdata;
  logic              r_b_err;

  logic              w_idle;
  logic              w_grant;
  logic              w_pick_b;
  logic [ADDR_W:0]   w_nbytes;
  logic [ADDR_W:0]   w_end;
  logic              w_err;
  logic [31:0]       w_rdata_nxt;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone requester wins; on contention the one not granted last.
  // Grants are masked while reset is asserted so every output reads 0 then.
  // ---------------------------------------------------------------------------
  assign w_idle   = (r_state == ST_IDLE) && rst;
  assign w_pick_b = b_req && (!a_req || (r_last == c_id_a));
  assign w_grant  = w_idle && (a_req || b_req);
  assign a_gnt    = w_grant && !w_pick_b;
  assign b_gnt    = w_grant && w_pick_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last  <= c_id_b;
      r_id    <= c_id_a;
      r_we    <= 1'b0;
      r_size  <= c_size_byte;
      r_sext  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_last  <= w_pick_b;
      r_id    <= w_pick_b;
      r_we    <= w_pick_b ? b_we    : a_we;
      r_size  <= w_pick_b ? b_size  : a_size;
      r_sext  <= w_pick_b ? b_sext  : a_sext;
      r_addr  <= w_pick_b ? b_addr  : a_addr;
      r_wdata <= w_pick_b ? b_wdata : a_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Error check on the latched request; the end address carries one extra bit
  // so an access near the top of the address space cannot wrap into range.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_nbytes = (ADDR_W+1)'(4);
    case (r_size)
      c_size_byte: w_nbytes = (ADDR_W+1)'(1);
      c_size_half: w_nbytes = (ADDR_W+1)'(2);
      default:     w_nbytes = (ADDR_W+1)'(4);
    endcase
  end

  assign w_end = {1'b0, r_addr} + w_nbytes;
  assign w_err = (r_size == c_size_bad)
              || ((r_size == c_size_half) && r_addr[0])
              || ((r_size == c_size_word) && (r_addr[1:0] != 2'b00))
              || (w_end > c_mem_limit);

  // ---------------------------------------------------------------------------
  // Next state and memory-side outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    write_mem_4B  = 1'b0;
    write_mem_2B  = 1'b0;
    write_mem_1B  = 1'b0;
    read_mem_4B   = 1'b0;
    read_mem_2B   = 1'b0;
    read_mem_1B   = 1'b0;
    extension_mem = 1'b0;
    address       = '0;
    write_data    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_IDLE;
        address     = r_addr;
        write_data  = r_wdata;
        if (!w_err) begin
          extension_mem = !r_we && r_sext;
          case (r_size)
            c_size_byte: begin
              write_mem_1B = r_we;
              read_mem_1B  = !r_we;
            end
            c_size_half: begin
              write_mem_2B = r_we;
              read_mem_2B  = !r_we;
            end
            default: begin
              write_mem_4B = r_we;
              read_mem_4B  = !r_we;
            end
          endcase
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Completion: rvalid pulses for one cycle, rdata/err hold until the next
  // completion for the same requester.
  // ---------------------------------------------------------------------------
  assign w_rdata_nxt = (!r_we && !w_err) ? out_mem : 32'h0000_0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_a_err    <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_b_rdata  <= '0;
      r_b_err    <= 1'b0;
    end else begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      if (r_state == ST_ACCESS) begin
        if (r_id == c_id_a) begin
          r_a_rvalid <= 1'b1;
          r_a_rdata  <= w_rdata_nxt;
          r_a_err    <= w_err;
        end else begin
          r_b_rvalid <= 1'b1;
          r_b_rdata  <= w_rdata_nxt;
          r_b_err    <= w_err;
        end
      end
    end
  end

  assign a_rvalid = r_a_rvalid;
  assign a_rdata  = r_a_rdata;
  assign a_err    = r_a_err;
  assign b_rvalid = r_b_rvalid;
  assign b_rdata  = r_b_rdata;
  assign b_err    = r_b_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Brief    : Self-checking bench for data_mem_arbiter with a byte-array memory
//            and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req, a_we, a_sext, b_req, b_we, b_sext;
  logic [1:0]  a_size, b_size;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        write_mem_4B, write_mem_2B, write_mem_1B;
  logic        read_mem_4B, read_mem_2B, read_mem_1B;
  logic        extension_mem;
  logic [31:0] address, write_data, out_mem;
  logic [5:0]  strb;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem     [0:1023];
  logic [7:0] ref_mem [0:1023];
  logic       init_mem;

  data_mem_arbiter #(.ADDR_W(32), .MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_sext(a_sext),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_sext(b_sext),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .b_rdata(b_rdata), .b_err(b_err),
    .write_mem_4B(write_mem_4B), .write_mem_2B(write_mem_2B), .write_mem_1B(write_mem_1B),
    .read_mem_4B(read_mem_4B), .read_mem_2B(read_mem_2B), .read_mem_1B(read_mem_1B),
    .extension_mem(extension_mem), .address(address), .write_data(write_data),
    .out_mem(out_mem)
  );

  assign strb = {write_mem_4B, write_mem_2B, write_mem_1B, read_mem_4B, read_mem_2B, read_mem_1B};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian memory: combinational read, store commits at the rising edge.
  always_comb begin
    out_mem = 32'h0;
    if (address < 32'd1024) begin
      if (read_mem_4B)
        out_mem = {mem[address[9:0]+10'd3], mem[address[9:0]+10'd2],
                   mem[address[9:0]+10'd1], mem[address[9:0]]};
      else if (read_mem_2B)
        out_mem = {{16{extension_mem & mem[address[9:0]+10'd1][7]}},
                   mem[address[9:0]+10'd1], mem[address[9:0]]};
      else if (read_mem_1B)
        out_mem = {{24{extension_mem & mem[address[9:0]][7]}}, mem[address[9:0]]};
    end
  end

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
    end else if (address < 32'd1024) begin
      if (write_mem_1B || write_mem_2B || write_mem_4B) mem[address[9:0]] <= write_data[7:0];
      if (write_mem_2B || write_mem_4B) mem[address[9:0]+10'd1] <= write_data[15:8];
      if (write_mem_4B) begin
        mem[address[9:0]+10'd2] <= write_data[23:16];
        mem[address[9:0]+10'd3] <= write_data[31:24];
      end
    end
  end

  // ---------------- reference model (transaction level) ----------------
  function automatic logic exp_err(input logic [1:0] sz, input logic [31:0] ad);
    logic [63:0] nb;
    nb = (sz == 2'd0) ? 64'd1 : (sz == 2'd1) ? 64'd2 : 64'd4;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && ad[0]) return 1'b1;
    if (sz == 2'd2 && ad[1:0] != 2'b00) return 1'b1;
    return ({32'h0, ad} + nb) > 64'd1024;
  endfunction

  function automatic logic [5:0] exp_strb(input logic we, input logic [1:0] sz, input logic er);
    int idx;
    if (er || sz == 2'd3) return 6'b0;
    idx = int'(sz) + (we ? 3 : 0);
    return 6'b000001 << idx;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sx, input logic [31:0] ad);
    int a;
    logic [31:0] v;
    a = int'(ad[9:0]);
    if (sz == 2'd0) begin
      v = {24'h0, ref_mem[a]};
      if (sx && ref_mem[a][7]) v[31:8] = 24'hFFFFFF;
    end else if (sz == 2'd1) begin
      v = {16'h0, ref_mem[a+1], ref_mem[a]};
      if (sx && ref_mem[a+1][7]) v[31:16] = 16'hFFFF;
    end else begin
      v = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] d);
    int a;
    a = int'(ad[9:0]);
    ref_mem[a] = d[7:0];
    if (sz != 2'd0) ref_mem[a+1] = d[15:8];
    if (sz == 2'd2) begin
      ref_mem[a+2] = d[23:16];
      ref_mem[a+3] = d[31:24];
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_sext = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_size = 2'd0; b_sext = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_gnt: a_gnt=%b b_gnt=%b, required 0 0", a_gnt, b_gnt);
    end
    a_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_err !== 1'b0 || b_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: rvalid=%b%b err=%b%b, required 00 00", a_rvalid, b_rvalid, a_err, b_err);
    end
    n_tests++;
    if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: a=%h b=%h, required 0", a_rdata, b_rdata);
    end
    n_tests++;
    if (strb !== 6'b0 || extension_mem !== 1'b0 || address !== 32'h0 || write_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_mem: strb=%b ext=%b addr=%h wd=%h, required all 0", strb, extension_mem, address, write_data);
    end
  endtask

  task automatic test_store_load();
    logic [1:0]  l_size [3];
    logic        l_sext [3];
    logic [31:0] l_addr [3];
    logic [31:0] l_exp  [3];
    logic [5:0]  l_strb [3];
    l_size = '{2'd0, 2'd1, 2'd2};
    l_sext = '{1'b1, 1'b0, 1'b0};
    l_addr = '{32'h13, 32'h12, 32'h10};
    l_exp  = '{32'hFFFF_FFDE, 32'h0000_DEAD, 32'hDEAD_BEEF};
    l_strb = '{6'b000001, 6'b000010, 6'b000100};

    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_size = 2'd2; a_sext = 1'b0; a_addr = 32'h10; a_wdata = 32'hDEADBEEF;
    #1;
    n_tests++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      n_fail++; $display("FAIL store_gnt: a_gnt=%b b_gnt=%b, required 1 0", a_gnt, b_gnt);
    end
    @(negedge clk);
    a_req = 1'b0;
    #1;
    n_tests++;
    if (strb !== 6'b100000 || address !== 32'h10 || write_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL store_access: strb=%b addr=%h wd=%h, required 100000 10 deadbeef", strb, address, write_data);
    end
    ref_store(2'd2, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    #1;
    n_tests++;
    if (a_rvalid !== 1'b1 || a_err !== 1'b0 || a_rdata !== 32'h0) begin
      n_fail++; $display("FAIL store_done: rvalid=%b err=%b rdata=%h, required 1 0 0", a_rvalid, a_err, a_rdata);
    end

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_req = 1'b1; b_we = 1'b0; b_size = l_size[i]; b_sext = l_sext[i]; b_addr = l_addr[i]; b_wdata = 32'h0;
      #1;
      n_tests++;
      if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
        n_fail++; $display("FAIL load%0d_gnt: b_gnt=%b a_gnt=%b, required 1 0", i, b_gnt, a_gnt);
      end
      @(negedge clk);
      b_req = 1'b0;
      #1;
      n_tests++;
      if (strb !== l_strb[i] || address !== l_addr[i] || extension_mem !== l_sext[i]) begin
        n_fail++; $display("FAIL load%0d_access: strb=%b addr=%h ext=%b, required %b %h %b",
                           i, strb, address, extension_mem, l_strb[i], l_addr[i], l_sext[i]);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (b_rvalid !== 1'b1 || b_err !== 1'b0 || b_rdata !== l_exp[i]) begin
        n_fail++; $display("FAIL load%0d_data: rvalid=%b err=%b rdata=%h, required 1 0 %h",
                           i, b_rvalid, b_err, b_rdata, l_exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ag, bg, arv, brv;
    apply_reset();
    a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_sext = 1'b0; a_addr = 32'h10; a_wdata = 32'h0;
    b_req = 1'b1; b_we = 1'b0; b_size = 2'd1; b_sext = 1'b1; b_addr = 32'h12; b_wdata = 32'h0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 8) begin a_req = 1'b0; b_req = 1'b0; end
      #1;
      ag  = (k == 0 || k == 4);
      bg  = (k == 2 || k == 6);
      arv = (k == 2 || k == 6);
      brv = (k == 4 || k == 8);
      n_tests++;
      if (a_gnt !== ag || b_gnt !== bg) begin
        n_fail++; $display("FAIL rr_gnt cyc%0d: a=%b b=%b, required %b %b", k, a_gnt, b_gnt, ag, bg);
      end
      n_tests++;
      if (a_rvalid !== arv || b_rvalid !== brv) begin
        n_fail++; $display("FAIL rr_rvalid cyc%0d: a=%b b=%b, required %b %b", k, a_rvalid, b_rvalid, arv, brv);
      end
      if (arv) begin
        n_tests++;
        if (a_rdata !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL rr_a_rdata cyc%0d: %h, required deadbeef", k, a_rdata);
        end
      end
      if (brv) begin
        n_tests++;
        if (b_rdata !== 32'hFFFFDEAD) begin
          n_fail++; $display("FAIL rr_b_rdata cyc%0d: %h, required ffffdead", k, b_rdata);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic        e_we   [4];
    logic [1:0]  e_size [4];
    logic [31:0] e_addr [4];
    e_we   = '{1'b0, 1'b1, 1'b0, 1'b0};
    e_size = '{2'd1, 2'd2, 2'd0, 2'd3};
    e_addr = '{32'h11, 32'h3FE, 32'h400, 32'h20};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_req = 1'b1; a_we = e_we[i]; a_size = e_size[i]; a_sext = 1'b1; a_addr = e_addr[i]; a_wdata = 32'hCAFEF00D;
      #1;
      n_tests++;
      if (a_gnt !== 1'b1) begin
        n_fail++; $display("FAIL err%0d_gnt: a_gnt=%b, required 1", i, a_gnt);
      end
      @(negedge clk);
      a_req = 1'b0;
      #1;
      n_tests++;
      if (strb !== 6'b0) begin
        n_fail++; $display("FAIL err%0d_strobe: strb=%b, required 000000", i, strb);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (a_rvalid !== 1'b1 || a_err !== 1'b1 || a_rdata !== 32'h0) begin
        n_fail++; $display("FAIL err%0d_done: rvalid=%b err=%b rdata=%h, required 1 1 0", i, a_rvalid, a_err, a_rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] expv;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_size = 2'd2; a_sext = 1'b0; a_addr = 32'h20; a_wdata = 32'h12345678;
    #1;
    n_tests++;
    if (a_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_gnt: a_gnt=%b, required 1", a_gnt);
    end
    @(negedge clk);
    a_req = 1'b0;
    #1;
    n_tests++;
    if (strb !== 6'b100000) begin
      n_fail++; $display("FAIL rstmid_access: strb=%b, required 100000", strb);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (strb !== 6'b0 || address !== 32'h0 || write_data !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_drop: strb=%b addr=%h wd=%h, required 0 0 0", strb, address, write_data);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || strb !== 6'b0) begin
        n_fail++; $display("FAIL rstmid_quiet%0d: rvalid=%b%b strb=%b, required 00 0", k, a_rvalid, b_rvalid, strb);
      end
      @(negedge clk);
    end
    a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_sext = 1'b0; a_addr = 32'h20; a_wdata = 32'h0;
    @(negedge clk);
    a_req = 1'b0;
    @(negedge clk);
    #1;
    expv = exp_load(2'd2, 1'b0, 32'h20);
    n_tests++;
    if (a_rvalid !== 1'b1 || a_rdata !== expv || a_rdata === 32'h12345678) begin
      n_fail++; $display("FAIL rstmid_reload: rvalid=%b rdata=%h, required 1 %h", a_rvalid, a_rdata, expv);
    end
  endtask

  task automatic test_random();
    logic        pend [2];
    logic        t_we [2];
    logic [1:0]  t_size [2];
    logic        t_sext [2];
    logic [31:0] t_addr [2];
    logic [31:0] t_wdata [2];
    logic [31:0] held_rd [2];
    logic        held_err [2];
    logic        f_we, f_sext, e_err, res_err, cancelled;
    logic [1:0]  f_size;
    logic [31:0] f_addr, f_wdata, res_rd;
    logic [5:0]  e_strb;
    int          f_p, grant_cyc, next_free, last, win, m, r;

    apply_reset();
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; t_we[p] = 1'b0; t_size[p] = 2'd0; t_sext[p] = 1'b0;
      t_addr[p] = 32'h0; t_wdata[p] = 32'h0; held_rd[p] = 32'h0; held_err[p] = 1'b0;
    end
    f_p = 0; f_we = 1'b0; f_sext = 1'b0; f_size = 2'd0; f_addr = 32'h0; f_wdata = 32'h0;
    res_rd = 32'h0; res_err = 1'b0;
    grant_cyc = -10; next_free = 0; last = 1;

    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        cancelled = 1'b0;
        if (pend[p] && $urandom_range(0, 15) == 0) begin
          pend[p] = 1'b0;
          cancelled = 1'b1;
        end
        if (!pend[p] && !cancelled && cyc < 290 && $urandom_range(0, 2) == 0) begin
          r = int'($urandom_range(0, 15));
          t_size[p] = (r == 0) ? 2'd3 : 2'(r % 3);
          t_we[p]   = 1'($urandom_range(0, 1));
          t_sext[p] = 1'($urandom_range(0, 1));
          t_wdata[p] = $urandom;
          m = int'($urandom_range(0, 15));
          if (m == 0)      t_addr[p] = 32'hFFFF_FFFC;
          else if (m == 1) t_addr[p] = 32'd1024 - $urandom_range(0, 3);
          else if (m < 4)  t_addr[p] = $urandom_range(0, 1023);
          else begin
            t_addr[p] = $urandom_range(0, 127);
            if (t_size[p] == 2'd2) t_addr[p][1:0] = 2'b00;
            if (t_size[p] == 2'd1) t_addr[p][0] = 1'b0;
          end
          pend[p] = 1'b1;
        end
      end
      a_req = pend[0]; a_we = t_we[0]; a_size = t_size[0]; a_sext = t_sext[0]; a_addr = t_addr[0]; a_wdata = t_wdata[0];
      b_req = pend[1]; b_we = t_we[1]; b_size = t_size[1]; b_sext = t_sext[1]; b_addr = t_addr[1]; b_wdata = t_wdata[1];
      #1;

      win = -1;
      if (cyc >= next_free) begin
        if (pend[0] && pend[1]) win = (last == 0) ? 1 : 0;
        else if (pend[0])       win = 0;
        else if (pend[1])       win = 1;
      end
      n_tests++;
      if (a_gnt !== (win == 0) || b_gnt !== (win == 1)) begin
        n_fail++; $display("FAIL rnd_gnt cyc%0d: a=%b b=%b, required %b %b", cyc, a_gnt, b_gnt, win == 0, win == 1);
      end

      if (cyc == grant_cyc + 1) begin
        e_err  = exp_err(f_size, f_addr);
        e_strb = exp_strb(f_we, f_size, e_err);
        n_tests++;
        if (strb !== e_strb) begin
          n_fail++; $display("FAIL rnd_strobe cyc%0d: %b, required %b (addr %h size %0d we %b)", cyc, strb, e_strb, f_addr, f_size, f_we);
        end
        if (!e_err) begin
          n_tests++;
          if (address !== f_addr || extension_mem !== (!f_we && f_sext) || (f_we && write_data !== f_wdata)) begin
            n_fail++; $display("FAIL rnd_drive cyc%0d: addr=%h ext=%b wd=%h, required %h %b %h",
                               cyc, address, extension_mem, write_data, f_addr, !f_we && f_sext, f_wdata);
          end
          if (f_we) ref_store(f_size, f_addr, f_wdata);
        end
        res_rd  = (!e_err && !f_we) ? exp_load(f_size, f_sext, f_addr) : 32'h0;
        res_err = e_err;
      end else begin
        n_tests++;
        if (strb !== 6'b0 || address !== 32'h0 || write_data !== 32'h0 || extension_mem !== 1'b0) begin
          n_fail++; $display("FAIL rnd_idle cyc%0d: strb=%b addr=%h wd=%h ext=%b, required all 0", cyc, strb, address, write_data, extension_mem);
        end
      end

      if (cyc == grant_cyc + 2) begin
        held_rd[f_p]  = res_rd;
        held_err[f_p] = res_err;
      end
      n_tests++;
      if (a_rvalid !== (cyc == grant_cyc + 2 && f_p == 0) || b_rvalid !== (cyc == grant_cyc + 2 && f_p == 1)) begin
        n_fail++; $display("FAIL rnd_rvalid cyc%0d: a=%b b=%b, required %b %b", cyc, a_rvalid, b_rvalid,
                           cyc == grant_cyc + 2 && f_p == 0, cyc == grant_cyc + 2 && f_p == 1);
      end
      n_tests++;
      if (a_rdata !== held_rd[0] || a_err !== held_err[0] || b_rdata !== held_rd[1] || b_err !== held_err[1]) begin
        n_fail++; $display("FAIL rnd_result cyc%0d: a=%h/%b b=%h/%b, required %h/%b %h/%b", cyc,
                           a_rdata, a_err, b_rdata, b_err, held_rd[0], held_err[0], held_rd[1], held_err[1]);
      end

      if (win >= 0) begin
        f_p = win; f_we = t_we[win]; f_size = t_size[win]; f_sext = t_sext[win];
        f_addr = t_addr[win]; f_wdata = t_wdata[win];
        grant_cyc = cyc; next_free = cyc + 2; last = win; pend[win] = 1'b0;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    init_mem = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    ref_mem[32'h20] = 8'h5A;
    ref_mem[32'h21] = 8'hC3;
    ref_mem[32'h22] = 8'h96;
    ref_mem[32'h23] = 8'h0F;
    @(posedge clk);
    #1 init_mem = 1'b0;

    test_reset();
    test_store_load();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_random();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and sequencer for the byte-addressed data memory. It accepts load/store requests from the core load/store port (A) and a debug/DMA port (B), and grants one at a time with round-robin fairness. It converts each granted request into the memory's one-hot size strobes, sign-extension flag, address and write data, and registers the read result back to the winning requester. Error checking covers misaligned, out-of-range and illegal-size accesses, which never reach the memory.

## Interface
- ADDR_W, 32, address width of both requesters and the memory.
- MEM_BYTES, 1024, memory size in bytes; the legal range is [0, MEM_BYTES).

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_req, b_req  in  1  request valid; held with its fields stable until the matching gnt.
- a_we, b_we  in  1  1 = store, 0 = load.
- a_size, b_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- a_sext, b_sext  in  1  sign-extend load result (byte/half only).
- a_addr, b_addr  in  ADDR_W  byte address.
- a_wdata, b_wdata  in  32  store data, right-aligned.
- a_gnt, b_gnt  out  1  combinational acceptance pulse, one cycle.
- a_rvalid, b_rvalid  out  1  registered completion pulse, one cycle; asserted for stores too.
- a_rdata, b_rdata  out  32  load data, valid with rvalid; 0 for stores and errors.
- a_err, b_err  out  1  error flag, valid with rvalid.
- write_mem_4B, write_mem_2B, write_mem_1B  out  1  memory store strobes, one-hot or all zero.
- read_mem_4B, read_mem_2B, read_mem_1B  out  1  memory load strobes, one-hot or all zero.
- extension_mem  out  1  sign-extension select to memory.
- address  out  ADDR_W  memory byte address.
- write_data  out  32  memory store data.
- out_mem  in  32  combinational memory read data.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: drives the memory for exactly one cycle.
- IDLE:
  - If any req is high, grant one requester, latch its we/size/sext/addr/wdata and its ID, and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - A single requester always wins.
  - If both requesters are high, the winner is the one not granted last.
  - The last-grant register resets to B, so A wins the first contention.
- Error check on the latched request:
  - size = 11.
  - half with addr[0] = 1.
  - word with addr[1:0] ≠ 00.
  - addr + bytes > MEM_BYTES; this sum is computed at ADDR_W+1 bits so it cannot wrap.
- ACCESS, legal request:
  - Exactly one strobe matching we/size is asserted.
  - extension_mem = sext for loads, 0 for stores.
  - address and write_data are driven from the latched request.
  - A store commits at the closing edge.
  - For a load, out_mem is captured into the winner's rdata at the closing edge.
- ACCESS, errored request: all strobes stay 0, rdata = 0, err = 1.
- Every ACCESS returns to IDLE and sets the winner's rvalid for the following cycle.
- In IDLE, all strobes, extension_mem, address and write_data are 0.
- Reset:
  - Immediately forces IDLE.
  - All outputs go to 0: gnt, rvalid, rdata, err, strobes, address, write_data.
  - Last-grant register = B.
  - A transaction interrupted in ACCESS is dropped: no rvalid, no memory write.

## Timing
- Cycle 0: req high in IDLE; gnt asserted combinationally and request latched at the edge.
- Cycle 1: ACCESS; memory strobes valid; store commits and load data is registered at the end of the cycle.
- Cycle 2: rvalid, rdata and err valid for one cycle. The FSM is back in IDLE, so a new gnt may fire in this same cycle.
- Peak throughput: one transaction per 2 cycles. Load latency from gnt to rvalid: 2 cycles.
- gnt is never asserted in ACCESS; a request arriving then waits.
- rdata and err hold their values until the next completion for that requester; only rvalid pulses.
- A requester deasserting req before gnt is legal; no transaction is issued.

## Test plan
- Reset, then a_req word store addr 0x10 data 0xDEADBEEF:
  - Before the request, all outputs are 0.
  - a_gnt in cycle 0.
  - Cycle 1: write_mem_4B = 1, address = 0x10, write_data = 0xDEADBEEF.
  - Cycle 2: a_rvalid = 1, a_err = 0.
- After the first test:
  - b byte load addr 0x13, sext = 1 -> b_rdata = 0xFFFFFFDE.
  - b half load addr 0x12, sext = 0 -> b_rdata = 0x0000DEAD.
  - b word load addr 0x10 -> b_rdata = 0xDEADBEEF.
- a_req and b_req both held high for 8 cycles after reset:
  - Grants alternate A, B, A, B on cycles 0, 2, 4, 6.
  - Each rvalid appears 2 cycles after its gnt.
- Error cases, each giving rvalid with err = 1, rdata = 0 and no strobe in ACCESS:
  - a half at 0x11.
  - a word at 0x3FE.
  - a byte at 0x400.
  - a size = 11.
- Reset mid-operation:
  - Assert rst low mid-cycle during ACCESS of a word store 0x12345678 to 0x20.
  - Strobes drop to 0 immediately and no rvalid follows.
  - A subsequent word load at 0x20 returns the prior contents, not 0x12345678.
